exec_stat_ctrl: RTL

Run/halt sequencer and statistics-counter controller for the single-cycle CPU. It gates the PC write enable and decides when the processor runs, pauses on a halt instruction, single-steps or resumes. It drives the enable and synchronous-reset inputs of the three 32-bit statistics counters: total cycles, jumps, and taken branches. It also rotates the display selector that chooses which counter the seven-segment display shows.

---
 rtl/exec_stat_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/exec_stat_ctrl.sv
// Run/halt sequencer for the single-cycle CPU: gates the PC write enable, drives the
// statistics-counter enables/clear and rotates the seven-segment display selector.
module exec_stat_ctrl #(
  parameter int unsigned SEL_PERIOD = 32'd1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       clr,
  input  logic       halt,
  input  logic       step_mode,
  input  logic       is_jmp,
  input  logic       is_br_taken,
  output logic       run_en,
  output logic       cyc_en,
  output logic       jmp_en,
  output logic       br_en,
  output logic       cnt_rst,
  output logic [1:0] sel,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_STEP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        ign_halt_q, ign_halt_d;
  logic [31:0] pre_q, pre_d;
  logic [1:0]  sel_q, sel_d;
  logic        active_s;
  logic        hlt_s;

  assign active_s = (state_q == S_RUN) || (state_q == S_STEP);
  // The halt that stopped us is still decoded on resume; mask it for one active cycle.
  assign hlt_s    = halt & ~ign_halt_q;

  assign run_en  = active_s & ~hlt_s;
  assign cyc_en  = active_s;
  assign jmp_en  = active_s & is_jmp & ~hlt_s;
  assign br_en   = active_s & is_br_taken & ~hlt_s;
  assign cnt_rst = clr | (go & (state_q == S_IDLE));
  assign sel     = sel_q;
  assign state   = state_q;

  // Next-state logic for the sequencer, halt mask and display prescaler.
  always_comb begin
    state_d    = state_q;
    ign_halt_d = ign_halt_q;
    case (state_q)
      S_IDLE: begin
        if (go) state_d = S_RUN;
        else    state_d = S_IDLE;
      end
      S_RUN: begin
        ign_halt_d = 1'b0;
        if (hlt_s)          state_d = S_HALT;
        else if (step_mode) state_d = S_HALT;
        else                state_d = S_RUN;
      end
      S_HALT: begin
        if (go) begin
          ign_halt_d = 1'b1;
          if (step_mode) state_d = S_STEP;
          else           state_d = S_RUN;
        end else begin
          state_d = S_HALT;
        end
      end
      S_STEP: begin
        ign_halt_d = 1'b0;
        state_d    = S_HALT;
      end
      default: begin
        ign_halt_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    if (pre_q >= SEL_PERIOD - 32'd1) begin
      pre_d = 32'd0;
      if (sel_q >= 2'd2) sel_d = 2'd0;
      else               sel_d = sel_q + 2'd1;
    end else begin
      pre_d = pre_q + 32'd1;
      sel_d = sel_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ign_halt_q <= 1'b0;
      pre_q      <= 32'd0;
      sel_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      ign_halt_q <= ign_halt_d;
      pre_q      <= pre_d;
      sel_q      <= sel_d;
    end
  end

endmodule
